// File: rtl/rob_pkg.sv
// Shared types and constants for the multi-issue re-order buffer.
// Optional squash logic is controlled by the ROB_RECOVER_EN macro.
package rob_pkg;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned PR_W   = 7;
    localparam int unsigned DISP_W = 2;
    localparam int unsigned RET_W  = 2;
    localparam int unsigned CDB_W  = 6;
    localparam int unsigned DCNT_W = $clog2(DISP_W + 1);
    localparam int unsigned RCNT_W = $clog2(RET_W + 1);
    localparam int unsigned CNT_W  = IDX_W + 1;

    localparam logic [PR_W-1:0] NULL_TAG = PR_W'(7'h7f);

    typedef struct packed {
        logic            valid;
        logic            ready;
        logic            halt;
        logic [PR_W-1:0] tag;
        logic [PR_W-1:0] told;
    } rob_entry_t;

    // Pointer arithmetic wraps naturally because DEPTH is a power of two
    function automatic logic [IDX_W-1:0] ptr_add(input logic [IDX_W-1:0] p,
                                                 input logic [IDX_W-1:0] k);
        return p + k;
    endfunction

endpackage

// File: rtl/rob_multi_if.sv
// Dispatch, CDB, retire and (with ROB_RECOVER_EN) recovery signals of the ROB.
interface rob_multi_if;
    import rob_pkg::*;

    logic [DCNT_W-1:0]       id_dispatch_num;
    logic [DISP_W*PR_W-1:0]  id_pr;
    logic [DISP_W*PR_W-1:0]  id_told;
    logic [DISP_W-1:0]       id_valid_inst;
    logic [DISP_W-1:0]       id_halt;
    logic [DCNT_W-1:0]       id_cap;
    logic [DISP_W*IDX_W-1:0] id_rob_idx;
    logic [CDB_W-1:0]        cdb_pr_ready;
    logic [CDB_W*PR_W-1:0]   cdb_pr_tag;
    logic [RCNT_W-1:0]       fl_retire_num;
    logic [RET_W*PR_W-1:0]   fl_retire_told;
    logic [RET_W*PR_W-1:0]   fl_retire_tag;
    logic                    retire_halt;
`ifdef ROB_RECOVER_EN
    logic                    br_recover;
    logic [IDX_W-1:0]        br_rob_idx;
`endif

    modport master (
`ifdef ROB_RECOVER_EN
        output br_recover, br_rob_idx,
`endif
        output id_dispatch_num, id_pr, id_told, id_valid_inst, id_halt,
        output cdb_pr_ready, cdb_pr_tag,
        input  id_cap, id_rob_idx, fl_retire_num, fl_retire_told, fl_retire_tag, retire_halt
    );

    modport slave (
`ifdef ROB_RECOVER_EN
        input  br_recover, br_rob_idx,
`endif
        input  id_dispatch_num, id_pr, id_told, id_valid_inst, id_halt,
        input  cdb_pr_ready, cdb_pr_tag,
        output id_cap, id_rob_idx, fl_retire_num, fl_retire_told, fl_retire_tag, retire_halt
    );

endinterface

// File: rtl/rob_retire_sel.sv
// In-order retire selection over the RET_W oldest entries; stops after a halt.
module rob_retire_sel
    import rob_pkg::*;
(
    input  rob_entry_t [RET_W-1:0] win,
    input  logic [CNT_W-1:0]       count,
    input  logic                   halted,
    output logic [RET_W-1:0]       mask,
    output logic [RCNT_W-1:0]      num
);

    logic go;

    always_comb begin
        mask = '0;
        num  = '0;
        go   = !halted;
        for (int j = 0; j < RET_W; j++) begin
            go      = go && (CNT_W'(j) < count) && win[j].valid && win[j].ready;
            mask[j] = go;
            if (go) num = num + RCNT_W'(1);
            go      = go && !win[j].halt;
        end
    end

endmodule

// File: rtl/rob_multi.sv
// Re-order buffer: multi-slot dispatch, CDB completion, in-order multi-retire.
// Define ROB_RECOVER_EN to add single-cycle mispredict squash.
module rob_multi
    import rob_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    rob_multi_if.slave rob
);

    rob_entry_t q   [DEPTH];
    rob_entry_t q_n [DEPTH];

    logic [IDX_W-1:0]       head, head_n, tail, tail_n;
    logic [CNT_W-1:0]       count, count_n, free;
    logic                   halted, halted_n;
    logic [DCNT_W-1:0]      cap, acc, acc_eff;
    rob_entry_t [RET_W-1:0] win;
    logic [RET_W-1:0]       ret_mask;
    logic [RCNT_W-1:0]      ret_num;
    logic                   ret_halt;
`ifdef ROB_RECOVER_EN
    logic [IDX_W-1:0]       sq_base, sq_len, sq_dist;
    logic [CNT_W-1:0]       span;
`endif

    // Capacity uses the occupancy before this cycle's retire
    always_comb begin
        free           = CNT_W'(DEPTH) - count;
        cap            = (free >= CNT_W'(DISP_W)) ? DCNT_W'(DISP_W) : DCNT_W'(free);
        acc            = (rob.id_dispatch_num < cap) ? rob.id_dispatch_num : cap;
        rob.id_cap     = cap;
        rob.id_rob_idx = '0;
        for (int k = 0; k < DISP_W; k++)
            rob.id_rob_idx[k*IDX_W +: IDX_W] = ptr_add(tail, IDX_W'(k));
    end

    always_comb begin
        for (int j = 0; j < RET_W; j++)
            win[j] = q[ptr_add(head, IDX_W'(j))];
    end

    rob_retire_sel u_retire_sel (
        .win    (win),
        .count  (count),
        .halted (halted),
        .mask   (ret_mask),
        .num    (ret_num)
    );

    always_comb begin
        rob.fl_retire_num  = ret_num;
        rob.fl_retire_told = '0;
        rob.fl_retire_tag  = '0;
        ret_halt           = 1'b0;
        for (int j = 0; j < RET_W; j++) begin
            rob.fl_retire_told[j*PR_W +: PR_W] = ret_mask[j] ? win[j].told : NULL_TAG;
            rob.fl_retire_tag[j*PR_W +: PR_W]  = ret_mask[j] ? win[j].tag  : NULL_TAG;
            ret_halt = ret_halt | (ret_mask[j] & win[j].halt);
        end
        rob.retire_halt = ret_halt;
    end

    // Next entry state: complete, retire, dispatch, then squash
    always_comb begin
        q_n      = q;
        acc_eff  = acc;
        halted_n = halted | ret_halt;
        head_n   = head + IDX_W'(ret_num);
`ifdef ROB_RECOVER_EN
        sq_base  = rob.br_rob_idx + IDX_W'(1);
        sq_len   = tail - sq_base;
        sq_dist  = rob.br_rob_idx - head;
        span     = CNT_W'(sq_dist) + CNT_W'(1);
        if (rob.br_recover) acc_eff = '0;
`endif
        for (int i = 0; i < DEPTH; i++)
            for (int c = 0; c < CDB_W; c++)
                if (rob.cdb_pr_ready[c] && q[i].valid && q[i].tag == rob.cdb_pr_tag[c*PR_W +: PR_W])
                    q_n[i].ready = 1'b1;
        for (int j = 0; j < RET_W; j++)
            if (ret_mask[j]) q_n[ptr_add(head, IDX_W'(j))] = '0;
        for (int k = 0; k < DISP_W; k++) begin
            if (DCNT_W'(k) < acc_eff) begin
                q_n[ptr_add(tail, IDX_W'(k))].valid = 1'b1;
                q_n[ptr_add(tail, IDX_W'(k))].ready = !rob.id_valid_inst[k];
                q_n[ptr_add(tail, IDX_W'(k))].halt  = rob.id_halt[k];
                q_n[ptr_add(tail, IDX_W'(k))].tag   = rob.id_pr[k*PR_W +: PR_W];
                q_n[ptr_add(tail, IDX_W'(k))].told  = rob.id_told[k*PR_W +: PR_W];
            end
        end
        tail_n  = tail + IDX_W'(acc_eff);
        count_n = count - CNT_W'(ret_num) + CNT_W'(acc_eff);
`ifdef ROB_RECOVER_EN
        if (rob.br_recover) begin
            for (int i = 0; i < DEPTH; i++)
                if ((IDX_W'(i) - sq_base) < sq_len) q_n[i] = '0;
            tail_n  = sq_base;
            count_n = (span > CNT_W'(ret_num)) ? span - CNT_W'(ret_num) : '0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else begin
            q      <= q_n;
            head   <= head_n;
            tail   <= tail_n;
            count  <= count_n;
            halted <= halted_n;
        end
    end

endmodule
